// File: rtl/merge_network_ctrl_pkg.sv
// rtl/merge_network_ctrl_pkg.sv - shared types, select encodings and key helper for the merge controller
package merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MERGE   = 2'd1,
        ST_DRAIN_A = 2'd2,
        ST_DRAIN_B = 2'd3
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Upper bounds for the generic key helper; callers zero-extend into these.
    localparam int unsigned MAX_BUNDLE_BITS = 1024;
    localparam int unsigned MAX_KEY_BITS    = 64;

    // Key of the top element (largest in an ascending bundle).
    function automatic logic [MAX_KEY_BITS-1:0] key_of_max(
        input logic [MAX_BUNDLE_BITS-1:0] bundle,
        input int unsigned                data_width,
        input int unsigned                bundle_width,
        input int unsigned                key_width
    );
        logic [MAX_BUNDLE_BITS-1:0] shifted;
        logic [MAX_KEY_BITS-1:0]    mask;
        shifted = bundle >> (data_width * (bundle_width - 1));
        mask    = (key_width >= MAX_KEY_BITS) ? '1
                                              : ((MAX_KEY_BITS'(1) << key_width) - MAX_KEY_BITS'(1));
        return shifted[MAX_KEY_BITS-1:0] & mask;
    endfunction

endpackage

// File: rtl/merge_network_ctrl_if.sv
// rtl/merge_network_ctrl_if.sv - FIFO-head, backpressure and merge-network signals of the controller
interface merge_network_ctrl_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BUNDLE_WIDTH  = 8,
    parameter int unsigned RUN_CNT_WIDTH = 16
);
    logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_a_bundle;
    logic                               i_a_empty;
    logic                               i_a_last;
    logic                               o_a_pop;
    logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_b_bundle;
    logic                               i_b_empty;
    logic                               i_b_last;
    logic                               o_b_pop;
    logic                               i_stall;
    logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] o_bundle;
    logic                               o_bundle_v;
    logic                               o_bundle_sel;
    logic                               o_bundle_last;
    logic                               o_run_done;
    logic [RUN_CNT_WIDTH-1:0]           o_run_cnt;
    logic                               o_busy;

    modport master (
        output i_a_bundle, i_a_empty, i_a_last, i_b_bundle, i_b_empty, i_b_last, i_stall,
        input  o_a_pop, o_b_pop, o_bundle, o_bundle_v, o_bundle_sel, o_bundle_last,
               o_run_done, o_run_cnt, o_busy
    );

    modport slave (
        input  i_a_bundle, i_a_empty, i_a_last, i_b_bundle, i_b_empty, i_b_last, i_stall,
        output o_a_pop, o_b_pop, o_bundle, o_bundle_v, o_bundle_sel, o_bundle_last,
               o_run_done, o_run_cnt, o_busy
    );
endinterface

// File: rtl/merge_network_ctrl_bundle_key_cmp.sv
// rtl/merge_network_ctrl_bundle_key_cmp.sv - combinational max-key compare of two bundle heads
module bundle_key_cmp
    import merge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned KEY_WIDTH    = 32,
    parameter int unsigned BUNDLE_WIDTH = 8
) (
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] a_bundle,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] b_bundle,
    output logic                               sel_b
);
    logic [MAX_KEY_BITS-1:0] key_a;
    logic [MAX_KEY_BITS-1:0] key_b;

    // Unsigned compare of the largest keys; equal keys favour A.
    always_comb begin
        key_a = key_of_max(MAX_BUNDLE_BITS'(a_bundle), DATA_WIDTH, BUNDLE_WIDTH, KEY_WIDTH);
        key_b = key_of_max(MAX_BUNDLE_BITS'(b_bundle), DATA_WIDTH, BUNDLE_WIDTH, KEY_WIDTH);
        sel_b = (key_a > key_b);
    end
endmodule

// File: rtl/merge_network_ctrl.sv
// rtl/merge_network_ctrl.sv - pop sequencer feeding the bundle merge network from two sorted FWFT runs
module merge_network_ctrl
    import merge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned KEY_WIDTH     = 32,
    parameter int unsigned BUNDLE_WIDTH  = 8,
    parameter int unsigned RUN_CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    merge_network_ctrl_if.slave  bus
);
    state_e state;
    state_e state_n;
    logic   pop_a;
    logic   pop_b;
    logic   pair_end;
    logic   sel_b;
    logic   both_ready;

    bundle_key_cmp #(
        .DATA_WIDTH   (DATA_WIDTH),
        .KEY_WIDTH    (KEY_WIDTH),
        .BUNDLE_WIDTH (BUNDLE_WIDTH)
    ) u_cmp (
        .a_bundle (bus.i_a_bundle),
        .b_bundle (bus.i_b_bundle),
        .sel_b    (sel_b)
    );

    assign both_ready = !bus.i_a_empty && !bus.i_b_empty;

    // Pop decision and next state; stall and emptiness gate the pops in the same cycle.
    always_comb begin
        state_n  = state;
        pop_a    = 1'b0;
        pop_b    = 1'b0;
        pair_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (both_ready) state_n = ST_MERGE;
            end
            ST_MERGE: begin
                if (both_ready && !bus.i_stall) begin
                    if (sel_b) begin
                        pop_b = 1'b1;
                        if (bus.i_b_last) state_n = ST_DRAIN_A;
                    end else begin
                        pop_a = 1'b1;
                        if (bus.i_a_last) state_n = ST_DRAIN_B;
                    end
                end
            end
            ST_DRAIN_A: begin
                if (!bus.i_a_empty && !bus.i_stall) begin
                    pop_a = 1'b1;
                    if (bus.i_a_last) begin
                        pair_end = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
            end
            ST_DRAIN_B: begin
                if (!bus.i_b_empty && !bus.i_stall) begin
                    pop_b = 1'b1;
                    if (bus.i_b_last) begin
                        pair_end = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.o_a_pop = pop_a;
    assign bus.o_b_pop = pop_b;
    assign bus.o_busy  = (state != ST_IDLE);

    // State register; reset aborts any run in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Registered merge-network drive, one cycle behind the pop; data holds between pops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_bundle      <= '0;
            bus.o_bundle_v    <= 1'b0;
            bus.o_bundle_sel  <= SEL_A;
            bus.o_bundle_last <= 1'b0;
            bus.o_run_done    <= 1'b0;
        end else begin
            bus.o_bundle_v    <= pop_a | pop_b;
            bus.o_bundle_last <= pair_end;
            bus.o_run_done    <= pair_end;
            if (pop_a) begin
                bus.o_bundle     <= bus.i_a_bundle;
                bus.o_bundle_sel <= SEL_A;
            end else if (pop_b) begin
                bus.o_bundle     <= bus.i_b_bundle;
                bus.o_bundle_sel <= SEL_B;
            end
        end
    end

    // Completed run-pair counter, wraps naturally at its width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      bus.o_run_cnt <= '0;
        else if (pair_end) bus.o_run_cnt <= bus.o_run_cnt + RUN_CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_merge_network_ctrl.sv
// tb/tb_merge_network_ctrl.sv - directed scoreboard bench for merge_network_ctrl
module tb_merge_network_ctrl;
    localparam int DW   = 32;
    localparam int BW   = 8;
    localparam int CW   = 2;
    localparam int BUSW = DW * BW;

    typedef struct {
        logic [BUSW-1:0] data;
        logic            last;
    } fifo_ent_t;

    typedef struct {
        logic [BUSW-1:0] data;
        logic            sel;
        logic            last;
    } exp_ent_t;

    logic clk;
    logic rst_n;

    merge_network_ctrl_if #(.DATA_WIDTH(DW), .BUNDLE_WIDTH(BW), .RUN_CNT_WIDTH(CW)) bus ();

    merge_network_ctrl #(
        .DATA_WIDTH    (DW),
        .KEY_WIDTH     (32),
        .BUNDLE_WIDTH  (BW),
        .RUN_CNT_WIDTH (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_ent_t afifo[$];
    fifo_ent_t bfifo[$];
    exp_ent_t  sb[$];

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    int pops_seen = 0;
    int valid_count = 0;
    int cyc = 0;
    int last_end_cyc = 0;
    logic prev_was_last = 1'b0;
    logic gap_chk = 1'b0;
    logic stall_r = 1'b0;
    logic b_block = 1'b0;
    logic prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [BUSW-1:0] obs, input logic [BUSW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BUSW-1:0] make_bundle(input int key);
        logic [BUSW-1:0] b;
        for (int i = 0; i < BW; i++) b[i*DW +: DW] = 32'(key * 16 + i);
        return b;
    endfunction

    // FIFO contents plus the reference merge order for one run pair.
    task automatic load_pair(input int na, input int a0, input int a1,
                             input int nb, input int b0, input int b1);
        int ak[2];
        int bk[2];
        int i;
        int j;
        int n;
        exp_ent_t e;
        fifo_ent_t f;
        ak[0] = a0; ak[1] = a1; bk[0] = b0; bk[1] = b1;
        for (int k = 0; k < na; k++) begin
            f.data = make_bundle(ak[k]); f.last = (k == na - 1); afifo.push_back(f);
        end
        for (int k = 0; k < nb; k++) begin
            f.data = make_bundle(bk[k]); f.last = (k == nb - 1); bfifo.push_back(f);
        end
        i = 0; j = 0; n = 0;
        while (i < na || j < nb) begin
            if (j >= nb || (i < na && ak[i] <= bk[j])) begin
                e.data = make_bundle(ak[i]); e.sel = 1'b0; i++;
            end else begin
                e.data = make_bundle(bk[j]); e.sel = 1'b1; j++;
            end
            e.last = (n == na + nb - 1);
            n++;
            sb.push_back(e);
        end
    endtask

    task automatic check_outputs();
        exp_ent_t e;
        if (prev_stall) chk("stall_no_valid", BUSW'(bus.o_bundle_v), BUSW'(0));
        if (bus.o_bundle_v) begin
            valid_count++;
            if (gap_chk && prev_was_last) chk("bubble_gap", BUSW'(cyc - last_end_cyc), BUSW'(2));
            if (sb.size() == 0) begin
                chk("unexpected_valid", BUSW'(bus.o_bundle_v), BUSW'(0));
            end else begin
                e = sb.pop_front();
                chk("bundle_data", bus.o_bundle, e.data);
                chk("bundle_sel", BUSW'(bus.o_bundle_sel), BUSW'(e.sel));
                chk("bundle_last", BUSW'(bus.o_bundle_last), BUSW'(e.last));
                chk("run_done", BUSW'(bus.o_run_done), BUSW'(e.last));
                if (e.last) begin
                    exp_cnt = (exp_cnt + 1) % (1 << CW);
                    chk("run_cnt", BUSW'(bus.o_run_cnt), BUSW'(exp_cnt));
                    last_end_cyc = cyc;
                end
                prev_was_last = e.last;
            end
        end else begin
            chk("idle_last", BUSW'({bus.o_bundle_last, bus.o_run_done}), BUSW'(0));
        end
    endtask

    // One clock: check registered outputs, present FIFO heads, then observe pops before the edge.
    task automatic tick();
        logic ae;
        logic be;
        @(negedge clk);
        cyc++;
        check_outputs();
        ae = (afifo.size() == 0);
        be = (bfifo.size() == 0) || b_block;
        bus.i_a_empty  = ae;
        bus.i_b_empty  = be;
        bus.i_a_bundle = ae ? '0 : afifo[0].data;
        bus.i_a_last   = ae ? 1'b0 : afifo[0].last;
        bus.i_b_bundle = be ? '0 : bfifo[0].data;
        bus.i_b_last   = be ? 1'b0 : bfifo[0].last;
        bus.i_stall    = stall_r;
        prev_stall     = stall_r;
        #1;
        if (bus.o_a_pop && bus.o_b_pop) chk("one_pop", 1, 0);
        if (bus.o_a_pop && (ae || stall_r)) chk("pop_a_guard", 1, 0);
        if (bus.o_b_pop && (be || stall_r)) chk("pop_b_guard", 1, 0);
        if (b_block) begin
            chk("merge_wait_pop", BUSW'({bus.o_a_pop, bus.o_b_pop}), BUSW'(0));
            chk("merge_wait_busy", BUSW'(bus.o_busy), BUSW'(1));
        end
        if (bus.o_a_pop && !ae) begin void'(afifo.pop_front()); pops_seen++; end
        if (bus.o_b_pop && !be) begin void'(bfifo.pop_front()); pops_seen++; end
    endtask

    task automatic run_to_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_busy || afifo.size() != 0 || bfifo.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, BUSW'(n >= 300), BUSW'(0));
        chk({tag, "_sb_empty"}, BUSW'(sb.size()), BUSW'(0));
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops_seen < target && n < 100) begin
            tick();
            n++;
        end
        chk("wait_pops_timeout", BUSW'(n >= 100), BUSW'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pops"}, BUSW'({bus.o_a_pop, bus.o_b_pop}), BUSW'(0));
        chk({tag, "_bundle"}, bus.o_bundle, '0);
        chk({tag, "_flags"}, BUSW'({bus.o_bundle_v, bus.o_bundle_sel, bus.o_bundle_last, bus.o_run_done}), BUSW'(0));
        chk({tag, "_run_cnt"}, BUSW'(bus.o_run_cnt), BUSW'(0));
        chk({tag, "_busy"}, BUSW'(bus.o_busy), BUSW'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        afifo.delete(); bfifo.delete(); sb.delete();
        exp_cnt = 0; prev_was_last = 1'b0; prev_stall = 1'b0;
        stall_r = 1'b0; b_block = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        bus.i_a_bundle = '0; bus.i_a_empty = 1'b1; bus.i_a_last = 1'b0;
        bus.i_b_bundle = '0; bus.i_b_empty = 1'b1; bus.i_b_last = 1'b0;
        bus.i_stall = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic merge: A {3,9}, B {5,7} -> A,B,B,A with last on the fourth.
        valid_count = 0;
        load_pair(2, 3, 9, 2, 5, 7);
        run_to_idle("basic");
        chk("basic_valids", BUSW'(valid_count), BUSW'(4));
        chk("basic_cnt", BUSW'(bus.o_run_cnt), BUSW'(1));

        // Tie on key 4: A first in MERGE, B drained with last.
        load_pair(1, 4, 0, 1, 4, 0);
        run_to_idle("tie");

        // Three stall cycles after the first pop.
        valid_count = 0;
        pops_seen = 0;
        load_pair(2, 3, 9, 2, 5, 7);
        wait_pops(1);
        stall_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pops", BUSW'({bus.o_a_pop, bus.o_b_pop}), BUSW'(0));
        end
        stall_r = 1'b0;
        run_to_idle("stall");
        chk("stall_valids", BUSW'(valid_count), BUSW'(4));

        // B held empty for five cycles mid-merge.
        pops_seen = 0;
        load_pair(2, 3, 9, 2, 5, 7);
        wait_pops(1);
        b_block = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        b_block = 1'b0;
        run_to_idle("empty");

        // Asynchronous reset after two pops, then a fresh pair.
        pops_seen = 0;
        load_pair(2, 3, 9, 2, 5, 7);
        wait_pops(2);
        do_reset();
        load_pair(2, 2, 6, 1, 4, 0);
        run_to_idle("post_reset");
        chk("post_reset_cnt", BUSW'(bus.o_run_cnt), BUSW'(1));

        // Five back-to-back single-bundle pairs with a 2-bit counter.
        do_reset();
        for (int k = 1; k <= 5; k++) load_pair(1, k * 2, 0, 1, k * 2 + 1, 0);
        gap_chk = 1'b1;
        prev_was_last = 1'b0;
        run_to_idle("wrap");
        gap_chk = 1'b0;
        chk("wrap_cnt", BUSW'(bus.o_run_cnt), BUSW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
